// File: rtl/tqvp_prism_cntbank.sv
// Counter/latch bank for the TinyQV PRISM peripheral: preloadable countdown timers,
// compare up-counters, an output latch and a masked interrupt status register.
module tqvp_prism_cntbank #(
  parameter int NUM_DOWN = 2,
  parameter int DOWN_W   = 27,
  parameter int NUM_UP   = 2,
  parameter int UP_W     = 4,
  parameter int LATCH_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          address,
  input  logic [31:0]         data_in,
  input  logic [1:0]          data_write_n,
  input  logic [1:0]          data_read_n,
  output logic [31:0]         data_out,
  output logic                data_ready,
  input  logic                fsm_halt,
  input  logic [NUM_DOWN-1:0] dn_dec,
  input  logic [NUM_DOWN-1:0] dn_load,
  input  logic [NUM_UP-1:0]   up_inc,
  input  logic [NUM_UP-1:0]   up_clr,
  input  logic                latch_en,
  input  logic [LATCH_W-1:0]  latch_d,
  output logic [NUM_DOWN-1:0] dn_zero,
  output logic [NUM_UP-1:0]   up_match,
  output logic [LATCH_W-1:0]  latched_q,
  output logic                user_interrupt
);

  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_STATUS = 6'h04;
  localparam logic [5:0] A_MASK   = 6'h08;
  localparam logic [5:0] A_LATCH  = 6'h0C;
  localparam logic [5:0] A_DN     = 6'h10;
  localparam logic [5:0] A_UP     = 6'h20;

  function automatic logic [15:0] valid_bits();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < NUM_DOWN; i++) v[i] = 1'b1;
    for (int j = 0; j < NUM_UP; j++) v[4+j] = 1'b1;
    v[15] = 1'b1;
    return v;
  endfunction

  localparam logic [15:0] STAT_VALID = valid_bits();

  logic                wr;
  logic                en;
  logic [NUM_DOWN-1:0] autoreload;
  logic [15:0]         status;
  logic [15:0]         mask;
  logic [15:0]         status_set;
  logic [15:0]         status_clr;
  logic                halt_q;
  logic [DOWN_W-1:0]   dn_count [NUM_DOWN];
  logic [DOWN_W-1:0]   dn_next  [NUM_DOWN];
  logic [DOWN_W-1:0]   preload  [NUM_DOWN];
  logic [UP_W-1:0]     up_count [NUM_UP];
  logic [UP_W-1:0]     up_next  [NUM_UP];
  logic [UP_W-1:0]     compare  [NUM_UP];
  logic                unused_inputs;

  assign wr             = (data_write_n == 2'b10);
  assign data_ready     = 1'b1;
  assign user_interrupt = |(status & mask);
  assign status_clr     = (wr && address == A_STATUS) ? data_in[15:0] : 16'h0000;
  assign unused_inputs  = ^{data_read_n, data_in};

  // Next counter values and the event bits they raise; halt freezes every channel.
  always_comb begin
    status_set = '0;
    for (int i = 0; i < NUM_DOWN; i++) begin
      dn_next[i] = dn_count[i];
      if (!fsm_halt) begin
        if (dn_dec[i] && !dn_load[i]) begin
          if (dn_count[i] == DOWN_W'(1)) begin
            status_set[i] = 1'b1;
            dn_next[i]    = autoreload[i] ? preload[i] : '0;
          end else if (dn_count[i] != '0) begin
            dn_next[i] = dn_count[i] - DOWN_W'(1);
          end
        end else if (dn_load[i] && !dn_dec[i] && en) begin
          dn_next[i] = preload[i];
        end
      end
    end
    for (int j = 0; j < NUM_UP; j++) begin
      up_next[j] = up_count[j];
      if (!fsm_halt) begin
        if (up_inc[j] && !up_clr[j]) begin
          up_next[j] = up_count[j] + UP_W'(1);
          if ((up_count[j] + UP_W'(1)) == compare[j]) status_set[4+j] = 1'b1;
        end else if (up_clr[j] && !up_inc[j] && en) begin
          up_next[j] = '0;
        end
      end
    end
    if (fsm_halt && !halt_q) status_set[15] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en         <= 1'b0;
      autoreload <= '0;
      status     <= '0;
      mask       <= '0;
      halt_q     <= 1'b0;
      latched_q  <= '0;
      for (int i = 0; i < NUM_DOWN; i++) begin
        dn_count[i] <= '0;
        preload[i]  <= '0;
      end
      for (int j = 0; j < NUM_UP; j++) begin
        up_count[j] <= '0;
        compare[j]  <= '0;
      end
    end else begin
      halt_q <= fsm_halt;
      // A hardware event in the same cycle as its W1C keeps the bit set.
      status <= (status & ~status_clr) | status_set;
      for (int i = 0; i < NUM_DOWN; i++) dn_count[i] <= dn_next[i];
      for (int j = 0; j < NUM_UP; j++) up_count[j] <= up_next[j];
      if (wr && address == A_CTRL) begin
        en         <= data_in[0];
        autoreload <= data_in[8 +: NUM_DOWN];
      end
      if (wr && address == A_MASK) mask <= data_in[15:0] & STAT_VALID;
      if (wr && address == A_LATCH) latched_q <= data_in[LATCH_W-1:0];
      else if (!fsm_halt && latch_en) latched_q <= latch_d;
      for (int i = 0; i < NUM_DOWN; i++)
        if (wr && address == A_DN + 6'(4 * i)) preload[i] <= data_in[DOWN_W-1:0];
      for (int j = 0; j < NUM_UP; j++)
        if (wr && address == A_UP + 6'(4 * j)) compare[j] <= data_in[UP_W-1:0];
    end
  end

  always_comb begin
    data_out = '0;
    if (address == A_CTRL) begin
      data_out[0]             = en;
      data_out[8 +: NUM_DOWN] = autoreload;
    end
    if (address == A_STATUS) data_out[15:0] = status;
    if (address == A_MASK) data_out[15:0] = mask;
    if (address == A_LATCH) data_out[LATCH_W-1:0] = latched_q;
    for (int i = 0; i < NUM_DOWN; i++)
      if (address == A_DN + 6'(4 * i)) data_out[DOWN_W-1:0] = dn_count[i];
    for (int j = 0; j < NUM_UP; j++)
      if (address == A_UP + 6'(4 * j)) begin
        data_out[16 +: UP_W] = compare[j];
        data_out[0 +: UP_W]  = up_count[j];
      end
  end

  always_comb begin
    dn_zero  = '0;
    up_match = '0;
    for (int i = 0; i < NUM_DOWN; i++) dn_zero[i] = (dn_count[i] == '0);
    for (int j = 0; j < NUM_UP; j++) up_match[j] = (up_count[j] == compare[j]);
  end

endmodule

// File: tb/tb_tqvp_prism_cntbank.sv
// Bench for tqvp_prism_cntbank: directed scenarios plus random stimulus against a
// behavioural model of the counter bank.
module tb_tqvp_prism_cntbank;
  localparam int ND = 2;
  localparam int DW = 27;
  localparam int NU = 2;
  localparam int UW = 4;
  localparam int LW = 4;
  localparam logic [15:0] VALID = 16'h8033;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [5:0]    address = '0;
  logic [31:0]   data_in = '0;
  logic [1:0]    data_write_n = 2'b11;
  logic [1:0]    data_read_n = 2'b11;
  logic [31:0]   data_out;
  logic          data_ready;
  logic          fsm_halt = 1'b0;
  logic [ND-1:0] dn_dec = '0, dn_load = '0, dn_zero;
  logic [NU-1:0] up_inc = '0, up_clr = '0, up_match;
  logic          latch_en = 1'b0;
  logic [LW-1:0] latch_d = '0, latched_q;
  logic          user_interrupt;

  int compared = 0;
  int mismatched = 0;

  int            m_dn [ND];
  int            m_pre[ND];
  int            m_up [NU];
  int            m_cmp[NU];
  bit            m_en;
  logic [ND-1:0] m_ar;
  logic [15:0]   m_stat, m_mask;
  logic [LW-1:0] m_latch;
  bit            m_halt_prev;

  tqvp_prism_cntbank dut (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
    .data_ready(data_ready), .fsm_halt(fsm_halt), .dn_dec(dn_dec), .dn_load(dn_load),
    .up_inc(up_inc), .up_clr(up_clr), .latch_en(latch_en), .latch_d(latch_d),
    .dn_zero(dn_zero), .up_match(up_match), .latched_q(latched_q),
    .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin m_dn[i] = 0; m_pre[i] = 0; end
    for (int j = 0; j < NU; j++) begin m_up[j] = 0; m_cmp[j] = 0; end
    m_en = 0; m_ar = '0; m_stat = '0; m_mask = '0; m_latch = '0; m_halt_prev = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit wr;
    logic [15:0] set;
    wr = (data_write_n == 2'b10);
    set = '0;
    if (!fsm_halt) begin
      for (int i = 0; i < ND; i++) begin
        if (dn_dec[i] && !dn_load[i]) begin
          if (m_dn[i] > 0) begin
            m_dn[i] = m_dn[i] - 1;
            if (m_dn[i] == 0) begin
              set[i] = 1'b1;
              if (m_ar[i]) m_dn[i] = m_pre[i];
            end
          end
        end else if (dn_load[i] && !dn_dec[i] && m_en) m_dn[i] = m_pre[i];
      end
      for (int j = 0; j < NU; j++) begin
        if (up_inc[j] && !up_clr[j]) begin
          m_up[j] = (m_up[j] + 1) % (1 << UW);
          if (m_up[j] == m_cmp[j]) set[4+j] = 1'b1;
        end else if (up_clr[j] && !up_inc[j] && m_en) m_up[j] = 0;
      end
    end
    if (fsm_halt && !m_halt_prev) set[15] = 1'b1;
    m_halt_prev = fsm_halt;
    if (wr && address == 6'h0C) m_latch = data_in[LW-1:0];
    else if (!fsm_halt && latch_en) m_latch = latch_d;
    if (wr && address == 6'h04) m_stat = m_stat & ~data_in[15:0];
    m_stat = m_stat | set;
    if (wr) begin
      if (address == 6'h00) begin m_en = data_in[0]; m_ar = data_in[8 +: ND]; end
      if (address == 6'h08) m_mask = data_in[15:0] & VALID;
      for (int i = 0; i < ND; i++) if (address == 6'(16 + 4 * i)) m_pre[i] = int'(data_in[DW-1:0]);
      for (int j = 0; j < NU; j++) if (address == 6'(32 + 4 * j)) m_cmp[j] = int'(data_in[UW-1:0]);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] a);
    logic [31:0] r;
    r = '0;
    if (a == 6'h00) begin r[0] = m_en; r[8 +: ND] = m_ar; end
    if (a == 6'h04) r[15:0] = m_stat;
    if (a == 6'h08) r[15:0] = m_mask;
    if (a == 6'h0C) r[LW-1:0] = m_latch;
    for (int i = 0; i < ND; i++) if (a == 6'(16 + 4 * i)) r = 32'(m_dn[i]);
    for (int j = 0; j < NU; j++) if (a == 6'(32 + 4 * j)) r = (32'(m_cmp[j]) << 16) | 32'(m_up[j]);
    return r;
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [5:0] a, input logic [31:0] v);
    address = a; data_in = v; data_write_n = 2'b10;
    cycle();
    data_write_n = 2'b11; data_in = '0;
  endtask

  task automatic peek(input logic [5:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    model_reset();
    #3 rst = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a <= 'h2C; a += 4) begin
      peek(6'(a), d);
      compared++;
      if (d !== 32'h0) begin $display("[TB] FAIL reset_read[%0h]: got %h want 0", a, d); mismatched++; end
    end
    compared++;
    if (dn_zero !== 2'b11) begin $display("[TB] FAIL reset_dn_zero: got %b want 11", dn_zero); mismatched++; end
    compared++;
    if (up_match !== 2'b11) begin $display("[TB] FAIL reset_up_match: got %b want 11", up_match); mismatched++; end
    compared++;
    if (user_interrupt !== 1'b0 || latched_q !== 4'h0 || data_ready !== 1'b1) begin
      $display("[TB] FAIL reset_outs: got irq=%b q=%h rdy=%b want 0 0 1", user_interrupt, latched_q, data_ready);
      mismatched++;
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_countdown();
    logic [31:0] d;
    int exp_seq[5] = '{3, 2, 1, 0, 0};
    write_reg(6'h10, 32'd3);
    write_reg(6'h00, 32'd1);
    write_reg(6'h08, 32'd1);
    dn_load = 2'b01; cycle(); dn_load = 2'b00;
    dn_dec = 2'b01;
    for (int k = 0; k < 5; k++) begin
      peek(6'h10, d);
      compared++;
      if (d !== 32'(exp_seq[k])) begin $display("[TB] FAIL dn_seq[%0d]: got %0d want %0d", k, d, exp_seq[k]); mismatched++; end
      compared++;
      if (user_interrupt !== (k >= 3)) begin $display("[TB] FAIL dn_irq[%0d]: got %b want %b", k, user_interrupt, k >= 3); mismatched++; end
      if (k < 4) cycle();
    end
    dn_dec = 2'b00;
    peek(6'h04, d);
    compared++;
    if (d !== 32'h1) begin $display("[TB] FAIL dn_status: got %h want 1", d); mismatched++; end
    compared++;
    if (dn_zero[0] !== 1'b1) begin $display("[TB] FAIL dn_zero0: got %b want 1", dn_zero[0]); mismatched++; end
    write_reg(6'h04, 32'd1);
    compared++;
    if (user_interrupt !== 1'b0) begin $display("[TB] FAIL dn_irq_w1c: got %b want 0", user_interrupt); mismatched++; end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    write_reg(6'h00, 32'h0000_0101);
    write_reg(6'h10, 32'd2);
    dn_load = 2'b01; cycle(); dn_load = 2'b00;
    dn_dec = 2'b01;
    for (int k = 0; k < 8; k++) begin
      peek(6'h10, d);
      compared++;
      if (d !== ((k % 2 == 0) ? 32'd2 : 32'd1)) begin $display("[TB] FAIL ar_seq[%0d]: got %0d", k, d); mismatched++; end
      compared++;
      if (dn_zero[0] !== 1'b0) begin $display("[TB] FAIL ar_zero[%0d]: got %b want 0", k, dn_zero[0]); mismatched++; end
      peek(6'h04, d);
      compared++;
      if (d[0] !== (k >= 2 && k % 2 == 0)) begin $display("[TB] FAIL ar_status[%0d]: got %b want %b", k, d[0], k >= 2 && k % 2 == 0); mismatched++; end
      if (k % 2 == 0) write_reg(6'h04, 32'd1);
      else cycle();
    end
    dn_dec = 2'b00;
    write_reg(6'h00, 32'd1);
    write_reg(6'h04, 32'hFFFF);
  endtask

  task automatic test_upcount();
    logic [31:0] d;
    write_reg(6'h20, 32'd5);
    compared++;
    if (up_match[0] !== 1'b0) begin $display("[TB] FAIL up_cmp_write: got %b want 0", up_match[0]); mismatched++; end
    write_reg(6'h08, 32'h10);
    for (int k = 1; k <= 5; k++) begin
      up_inc = 2'b01; cycle(); up_inc = 2'b00;
      compared++;
      if (up_match[0] !== (k == 5)) begin $display("[TB] FAIL up_match[%0d]: got %b want %b", k, up_match[0], k == 5); mismatched++; end
      peek(6'h04, d);
      compared++;
      if (d[4] !== (k == 5) || user_interrupt !== (k == 5)) begin
        $display("[TB] FAIL up_status[%0d]: got st=%b irq=%b want %b", k, d[4], user_interrupt, k == 5);
        mismatched++;
      end
      cycle();
    end
    up_inc = 2'b01; repeat (10) cycle(); up_inc = 2'b00;
    peek(6'h20, d);
    compared++;
    if (d !== 32'h0005_000F) begin $display("[TB] FAIL up_at15: got %h want 0005000f", d); mismatched++; end
    up_inc = 2'b01; cycle(); up_inc = 2'b00;
    peek(6'h20, d);
    compared++;
    if (d !== 32'h0005_0000) begin $display("[TB] FAIL up_wrap: got %h want 00050000", d); mismatched++; end
    up_inc = 2'b01; repeat (3) cycle(); up_inc = 2'b00;
    write_reg(6'h00, 32'd0);
    up_clr = 2'b01; cycle(); up_clr = 2'b00;
    peek(6'h20, d);
    compared++;
    if (d !== 32'h0005_0003) begin $display("[TB] FAIL up_clr_disabled: got %h want 00050003", d); mismatched++; end
    write_reg(6'h00, 32'd1);
    up_clr = 2'b01; cycle(); up_clr = 2'b00;
    peek(6'h20, d);
    compared++;
    if (d !== 32'h0005_0000) begin $display("[TB] FAIL up_clr_enabled: got %h want 00050000", d); mismatched++; end
    write_reg(6'h04, 32'hFFFF);
    write_reg(6'h08, 32'h0);
  endtask

  task automatic test_halt();
    logic [31:0] d;
    write_reg(6'h10, 32'd9);
    dn_load = 2'b01; cycle(); dn_load = 2'b00;
    latch_en = 1'b1; latch_d = 4'h5; cycle(); latch_en = 1'b0;
    compared++;
    if (latched_q !== 4'h5) begin $display("[TB] FAIL latch_capture: got %h want 5", latched_q); mismatched++; end
    write_reg(6'h08, 32'h8000);
    fsm_halt = 1'b1; dn_dec = 2'b11; up_inc = 2'b11; latch_en = 1'b1; latch_d = 4'hA;
    cycle();
    compared++;
    if (user_interrupt !== 1'b1) begin $display("[TB] FAIL halt_rise_irq: got %b want 1", user_interrupt); mismatched++; end
    repeat (2) cycle();
    peek(6'h10, d);
    compared++;
    if (d !== 32'd9) begin $display("[TB] FAIL halt_dn: got %0d want 9", d); mismatched++; end
    peek(6'h20, d);
    compared++;
    if (d !== 32'h0005_0000) begin $display("[TB] FAIL halt_up: got %h want 00050000", d); mismatched++; end
    peek(6'h04, d);
    compared++;
    if (d !== 32'h8000 || latched_q !== 4'h5) begin $display("[TB] FAIL halt_state: got st=%h q=%h want 8000 5", d, latched_q); mismatched++; end
    write_reg(6'h0C, 32'h3);
    compared++;
    if (latched_q !== 4'h3) begin $display("[TB] FAIL halt_latch_write: got %h want 3", latched_q); mismatched++; end
    fsm_halt = 1'b0; dn_dec = 2'b00; up_inc = 2'b00;
    write_reg(6'h0C, 32'h6);
    compared++;
    if (latched_q !== 4'h6) begin $display("[TB] FAIL latch_write_wins: got %h want 6", latched_q); mismatched++; end
    cycle();
    latch_en = 1'b0;
    compared++;
    if (latched_q !== 4'hA) begin $display("[TB] FAIL latch_after_write: got %h want a", latched_q); mismatched++; end
    write_reg(6'h04, 32'hFFFF);
    write_reg(6'h08, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    write_reg(6'h10, 32'd1);
    dn_load = 2'b01; cycle(); dn_load = 2'b00;
    dn_dec = 2'b01;
    write_reg(6'h04, 32'd1);
    dn_dec = 2'b00;
    peek(6'h04, d);
    compared++;
    if (d[0] !== 1'b1 || dn_zero[0] !== 1'b1) begin $display("[TB] FAIL w1c_vs_set: got st=%b z=%b want 1 1", d[0], dn_zero[0]); mismatched++; end
    write_reg(6'h10, 32'd7);
    dn_load = 2'b01; cycle(); dn_load = 2'b00;
    write_reg(6'h10, 32'd4);
    peek(6'h10, d);
    compared++;
    if (d !== 32'd7) begin $display("[TB] FAIL preload_no_effect: got %0d want 7", d); mismatched++; end
    dn_dec = 2'b01; dn_load = 2'b01; cycle(); dn_dec = 2'b00; dn_load = 2'b00;
    peek(6'h10, d);
    compared++;
    if (d !== 32'd7) begin $display("[TB] FAIL dec_load_hold: got %0d want 7", d); mismatched++; end
    up_inc = 2'b01; cycle();
    up_clr = 2'b01; cycle(); up_inc = 2'b00; up_clr = 2'b00;
    peek(6'h20, d);
    compared++;
    if (d !== 32'h0005_0001) begin $display("[TB] FAIL inc_clr_hold: got %h want 00050001", d); mismatched++; end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [5:0] wa;
    logic [ND-1:0] ez;
    logic [NU-1:0] em;
    logic [5:0] waddr[8] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h20, 6'h24};
    for (int n = 0; n < 400; n++) begin
      fsm_halt = ($urandom_range(0, 9) == 0);
      dn_dec   = ND'($urandom); dn_load = ND'($urandom & $urandom);
      up_inc   = NU'($urandom); up_clr  = NU'($urandom & $urandom);
      latch_en = 1'($urandom); latch_d = LW'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        wa = waddr[$urandom_range(0, 7)];
        address = wa;
        if (wa >= 6'h10 && wa < 6'h20) data_in = $urandom_range(0, 6);
        else data_in = $urandom;
        data_write_n = 2'b10;
      end
      cycle();
      data_write_n = 2'b11;
      for (int i = 0; i < ND; i++) ez[i] = (m_dn[i] == 0);
      for (int j = 0; j < NU; j++) em[j] = (m_up[j] == m_cmp[j]);
      compared++;
      if (dn_zero !== ez || up_match !== em || latched_q !== m_latch || user_interrupt !== |(m_stat & m_mask)) begin
        $display("[TB] FAIL rand_outs[%0d]: got z=%b m=%b q=%h irq=%b want %b %b %h %b", n, dn_zero, up_match,
                 latched_q, user_interrupt, ez, em, m_latch, |(m_stat & m_mask));
        mismatched++;
      end
      wa = 6'($urandom_range(0, 15) * 4);
      peek(wa, d);
      compared++;
      if (d !== model_read(wa)) begin $display("[TB] FAIL rand_read[%0d] @%h: got %h want %h", n, wa, d, model_read(wa)); mismatched++; end
    end
    fsm_halt = 1'b0; dn_dec = '0; dn_load = '0; up_inc = '0; up_clr = '0; latch_en = 1'b0;
    cycle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    write_reg(6'h00, 32'd1);
    write_reg(6'h10, 32'd5);
    dn_load = 2'b01; cycle(); dn_load = 2'b00;
    rst = 1'b1;
    #1;
    compared++;
    if (dn_zero !== 2'b11 || up_match !== 2'b11 || latched_q !== 4'h0) begin
      $display("[TB] FAIL mid_reset_outs: got z=%b m=%b q=%h want 11 11 0", dn_zero, up_match, latched_q);
      mismatched++;
    end
    model_reset();
    up_inc = 2'b01;
    rst = 1'b0;
    cycle();
    up_inc = 2'b00;
    peek(6'h20, d);
    compared++;
    if (d !== 32'h0000_0001) begin $display("[TB] FAIL resume_after_reset: got %h want 00000001", d); mismatched++; end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_autoreload();
    test_upcount();
    test_halt();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
